subtractor_4_bit_serial: RTL and testbench

- Bit-serial 4-bit subtractor with borrow-in and borrow-out. Computes diff = a - b - bin, one bit per clock, LSB first, using a single borrow flip-flop.
- It is the sequential, area-reduced companion to the combinational 4-bit adder in the arith netlist set, covering the opposite arithmetic direction.
- Operands are captured on a start handshake. The result is presented as bit-level outputs with a one-cycle done pulse.

---
 rtl/subtractor_4_bit_serial.sv | 128 ++++++++++++
 tb/tb_subtractor_4_bit_serial.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/subtractor_4_bit_serial.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_4_bit_serial
// Purpose  : Bit-serial 4-bit subtractor, diff = a - b - bin (mod 16).
//            One bit per clock, LSB first, using a single borrow flip-flop.
//            Operands are captured on start; the result is presented in
//            parallel together with a one-cycle done pulse.
// Ports    : clk            - clock, rising edge
//            rst            - asynchronous active-high reset
//            start          - begin an operation (ignored while busy)
//            bin            - borrow-in, captured with start
//            a_0..a_3       - minuend bits (a_0 = LSB), captured with start
//            b_0..b_3       - subtrahend bits (b_0 = LSB), captured with start
//            diff_0..diff_3 - registered difference bits (diff_0 = LSB)
//            bout           - registered borrow-out of the MSB
//            busy           - operation in progress
//            done           - one-cycle pulse, result valid from this cycle
// Revision : 1.0 - initial release
// ============================================================================
module subtractor_4_bit_serial (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bin,
  input  logic a_0,
  input  logic a_1,
  input  logic a_2,
  input  logic a_3,
  input  logic b_0,
  input  logic b_1,
  input  logic b_2,
  input  logic b_3,
  output logic diff_0,
  output logic diff_1,
  output logic diff_2,
  output logic diff_3,
  output logic bout,
  output logic busy,
  output logic done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] C_LAST_BIT = 2'd3;

  state_t     r_state;
  logic [3:0] r_a;      // minuend, shifted right so bit i sits at [0]
  logic [3:0] r_b;      // subtrahend, shifted right the same way
  logic       r_br;     // running borrow
  logic [1:0] r_cnt;    // index of the bit processed on the next edge
  logic [3:0] r_res;    // partial result, filled from the MSB side
  logic [3:0] r_diff;
  logic       r_bout;
  logic       r_busy;
  logic       r_done;

  logic       w_a_bit;
  logic       w_b_bit;
  logic       w_d;
  logic       w_br_next;
  logic [3:0] w_res_next;

  // Full-subtractor cell for the current bit
  assign w_a_bit    = r_a[0];
  assign w_b_bit    = r_b[0];
  assign w_d        = w_a_bit ^ w_b_bit ^ r_br;
  assign w_br_next  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
  // After four shifts the first computed bit has reached position 0
  assign w_res_next = {w_d, r_res[3:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_br    <= 1'b0;
      r_cnt   <= 2'd0;
      r_res   <= 4'd0;
      r_diff  <= 4'd0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= {a_3, a_2, a_1, a_0};
            r_b     <= {b_3, b_2, b_1, b_0};
            r_br    <= bin;
            r_cnt   <= 2'd0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= {1'b0, r_a[3:1]};
          r_b   <= {1'b0, r_b[3:1]};
          r_br  <= w_br_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + 2'd1;
          // Outputs update only here, so no partial result is ever visible
          if (r_cnt == C_LAST_BIT) begin
            r_diff  <= w_res_next;
            r_bout  <= w_br_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign diff_0 = r_diff[0];
  assign diff_1 = r_diff[1];
  assign diff_2 = r_diff[2];
  assign diff_3 = r_diff[3];
  assign bout   = r_bout;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_4_bit_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtractor_4_bit_serial
// Purpose  : Self-checking bench for subtractor_4_bit_serial. Expected
//            {bout, diff} values are queued when an operation is started and
//            popped when done is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subtractor_4_bit_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic       bin_i;
  logic [3:0] a_v;
  logic [3:0] b_v;
  logic [3:0] d_v;
  logic       bout_o;
  logic       busy_o;
  logic       done_o;

  logic [4:0] sb[$];   // {bout, diff}
  int         n_cmp;
  int         n_err;

  subtractor_4_bit_serial dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin    (bin_i),
    .a_0    (a_v[0]),
    .a_1    (a_v[1]),
    .a_2    (a_v[2]),
    .a_3    (a_v[3]),
    .b_0    (b_v[0]),
    .b_1    (b_v[1]),
    .b_2    (b_v[2]),
    .b_3    (b_v[3]),
    .diff_0 (d_v[0]),
    .diff_1 (d_v[1]),
    .diff_2 (d_v[2]),
    .diff_3 (d_v[3]),
    .bout   (bout_o),
    .busy   (busy_o),
    .done   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands with start at the current falling edge, queue the
  // expected result, and return one falling edge after the capture edge.
  task automatic start_op(input int a, input int b, input int bi);
    int r;
    logic [4:0] e;
    a_v   = a[3:0];
    b_v   = b[3:0];
    bin_i = bi[0];
    start = 1'b1;
    r     = a - b - bi;
    e[3:0] = r[3:0];
    e[4]   = (a < b + bi);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; counts falling edges and cycles with busy high.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = busy_o ? 1 : 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy_o) nbusy++;
    end while (!done_o && cyc < 12);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_v = 4'd0; b_v = 4'd0; bin_i = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
    n_cmp++; if ({bout_o, d_v} !== 5'd0) begin n_err++; $display("FAIL reset_out got %b want 00000", {bout_o, d_v}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input int a, input int b, input int bi);
    int cyc, nb;
    logic [4:0] e;
    start_op(a, b, bi);
    wait_done(cyc, nb);
    e = sb.pop_front();
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL basic_timeout a=%0d b=%0d done=%b", a, b, done_o); end
    n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL basic_latency a=%0d b=%0d got %0d want 4", a, b, cyc); end
    n_cmp++; if (nb != 4) begin n_err++; $display("FAIL basic_busy_cycles a=%0d b=%0d got %0d want 4", a, b, nb); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_busy_with_done got %b want 0", busy_o); end
    n_cmp++; if ({bout_o, d_v} !== e) begin n_err++; $display("FAIL basic_result a=%0d b=%0d bin=%0d got %b want %b", a, b, bi, {bout_o, d_v}, e); end
    @(negedge clk);
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b want 0", done_o); end
    n_cmp++; if ({bout_o, d_v} !== e) begin n_err++; $display("FAIL basic_hold got %b want %b", {bout_o, d_v}, e); end
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    logic [4:0] e;
    start_op(0, 0, 1);
    wait_done(cyc, nb);
    e = sb.pop_front();
    n_cmp++; if ({bout_o, d_v} !== e) begin n_err++; $display("FAIL b2b_first got %b want %b", {bout_o, d_v}, e); end
    // Second start issued in the done cycle
    start_op(15, 15, 0);
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_accept busy got %b want 1", busy_o); end
    wait_done(cyc, nb);
    e = sb.pop_front();
    n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL b2b_latency got %0d want 4", cyc); end
    n_cmp++; if ({bout_o, d_v} !== e) begin n_err++; $display("FAIL b2b_second got %b want %b", {bout_o, d_v}, e); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int cyc, nb, ndone;
    logic [4:0] e;
    start_op(5, 2, 0);
    @(negedge clk);
    a_v = 4'd1; b_v = 4'd7; bin_i = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, nb);
    e = sb.pop_front();
    n_cmp++; if (cyc != 2) begin n_err++; $display("FAIL ignore_latency got %0d want 2", cyc); end
    n_cmp++; if ({bout_o, d_v} !== e) begin n_err++; $display("FAIL ignore_result got %b want %b", {bout_o, d_v}, e); end
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL ignore_extra_done got %0d want 0", ndone); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ignore_busy_after got %b want 0", busy_o); end
  endtask

  task automatic test_reset_abort();
    int cyc, nb;
    logic [4:0] e;
    start_op(12, 4, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", done_o); end
    n_cmp++; if ({bout_o, d_v} !== 5'd0) begin n_err++; $display("FAIL abort_out got %b want 00000", {bout_o, d_v}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL abort_late_done got %b want 0", done_o); end
    start_op(12, 4, 1);
    wait_done(cyc, nb);
    e = sb.pop_front();
    n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL abort_restart_latency got %0d want 4", cyc); end
    n_cmp++; if ({bout_o, d_v} !== e) begin n_err++; $display("FAIL abort_restart_result got %b want %b", {bout_o, d_v}, e); end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int cyc, nb;
    logic [4:0] e;
    for (int i = 0; i < 512; i++) begin
      start_op(i & 15, (i >> 4) & 15, (i >> 8) & 1);
      wait_done(cyc, nb);
      e = sb.pop_front();
      n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL sweep_latency i=%0d got %0d want 4", i, cyc); end
      n_cmp++; if ({bout_o, d_v} !== e) begin n_err++; $display("FAIL sweep_result i=%0d got %b want %b", i, {bout_o, d_v}, e); end
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic(9, 3, 0);
    test_basic(3, 9, 0);
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_sweep();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
